// File: rtl/result_pager.sv
// Result pager: accepts a finished calculator result and pages it onto 16 LEDs,
// advancing one 16-bit page per debounced press of btn_next.
module result_pager #(
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int CNT_W           = 20
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        res_valid,
    output logic        res_ready,
    input  logic [63:0] res_data,
    input  logic        res_sign,
    input  logic [1:0]  res_size,
    input  logic        btn_next,
    output logic [15:0] led,
    output logic [1:0]  page_idx,
    output logic        sign_led,
    output logic        busy,
    output logic        done_pulse
);

    typedef enum logic {S_IDLE, S_SHOW} state_t;

    state_t             r_state;
    logic               r_sync1;
    logic               r_sync2;
    logic               r_db;
    logic               r_db_prev;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_data;
    logic [1:0]         r_last;
    logic [1:0]         r_page;
    logic [15:0]        r_led;
    logic               r_sign_led;
    logic               r_busy;
    logic               r_ready;
    logic               r_done;

    logic               w_next;
    logic [1:0]         w_page_nxt;

    assign w_next     = r_db & ~r_db_prev;
    assign w_page_nxt = r_page + 2'd1;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_sync1   <= 1'b0;
            r_sync2   <= 1'b0;
            r_db      <= 1'b0;
            r_db_prev <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= btn_next;
            r_sync2   <= r_sync1;
            r_db_prev <= r_db;
            // The level must disagree for DEBOUNCE_CYCLES consecutive samples before it is taken.
            if (r_sync2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_sync2;
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_data     <= '0;
            r_last     <= '0;
            r_page     <= '0;
            r_led      <= '0;
            r_sign_led <= 1'b0;
            r_busy     <= 1'b0;
            r_ready    <= 1'b1;
            r_done     <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (res_valid && r_ready) begin
                        r_data     <= res_data;
                        r_last     <= (res_size == 2'd0) ? 2'd0 :
                                      (res_size == 2'd1) ? 2'd1 : 2'd3;
                        r_page     <= '0;
                        r_led      <= res_data[15:0];
                        r_sign_led <= res_sign;
                        r_busy     <= 1'b1;
                        r_ready    <= 1'b0;
                        r_state    <= S_SHOW;
                    end
                end
                S_SHOW: begin
                    if (w_next) begin
                        if (r_page == r_last) begin
                            r_page     <= '0;
                            r_led      <= '0;
                            r_sign_led <= 1'b0;
                            r_busy     <= 1'b0;
                            r_ready    <= 1'b1;
                            r_done     <= 1'b1;
                            r_state    <= S_IDLE;
                        end else begin
                            r_page <= w_page_nxt;
                            r_led  <= r_data[{w_page_nxt, 4'b0000} +: 16];
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign res_ready  = r_ready;
    assign led        = r_led;
    assign page_idx   = r_page;
    assign sign_led   = r_sign_led;
    assign busy       = r_busy;
    assign done_pulse = r_done;

endmodule

// File: doc/result_pager.md
Name: result_pager

Overview:
- Output-side counterpart to the calculator's switch/button input sequencer.
- Accepts a finished result (up to 64 bits, plus sign and operand size) from the calculator core over a valid/ready handshake.
- Presents the result to the user on 16 LEDs, one 16-bit page at a time. The user steps through pages with a debounced push button.
- Sits between the arithmetic units and the board LEDs.

Parameters:
- DEBOUNCE_CYCLES, 16, number of consecutive stable synchronized samples needed to accept a button level change (board build uses 1000000).
- CNT_W, 20, width of the debounce counter; must hold DEBOUNCE_CYCLES.

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- res_valid  input  1  result available from calculator
- res_ready  output  1  pager can accept a result
- res_data  input  64  result value, LSB-aligned
- res_sign  input  1  result sign flag
- res_size  input  2  0 = 16-bit, 1 = 32-bit, 2 = 64-bit, 3 = treated as 64-bit
- btn_next  input  1  raw asynchronous push button, active-high
- led  output  16  currently displayed page of the result
- page_idx  output  2  index of the page being displayed
- sign_led  output  1  latched sign while displaying
- busy  output  1  high while a result is being displayed
- done_pulse  output  1  one-cycle pulse when the last page is dismissed

Behaviour:
- Reset (rst low, asynchronous):
  - State IDLE.
  - res_ready=1; led=0, page_idx=0, sign_led=0, busy=0, done_pulse=0.
  - Latched data, sign and page count cleared.
  - Synchronizer flops, debounced level and debounce counter cleared to 0.
  - Reset mid-display abandons the result; no done_pulse.
- Button path:
  - Two-flop synchronizer on btn_next.
  - Counter clears whenever the synchronized level equals the debounced level. Otherwise it increments.
  - When the counter reaches DEBOUNCE_CYCLES-1, the debounced level takes the synchronized level and the counter clears.
  - A rising edge of the debounced level produces a one-cycle next_pulse.
  - Glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
  - Releases produce no pulse.
  - A button held through reset release registers as one press after debounce.
- State IDLE:
  - res_ready=1, busy=0, led=0, sign_led=0, page_idx=0.
  - On a clock edge with res_valid & res_ready: latch res_data and res_sign; set num_pages = 1/2/4 from res_size; page=0; go to SHOW.
  - next_pulse in IDLE is discarded.
- State SHOW:
  - res_ready=0, busy=1, sign_led=latched sign, page_idx=page, led=latched_data[16*page +: 16].
  - All outputs are registered, so led shows page 0 in the cycle after the handshake edge.
  - On next_pulse with page < num_pages-1: page increments; led updates the following cycle.
  - On next_pulse with page == num_pages-1: go to IDLE and assert done_pulse for exactly one cycle, coincident with res_ready returning to 1.
  - res_valid is ignored in SHOW; the upstream source must hold it until accepted.
- Simultaneous events:
  - done_pulse and a new res_valid: the new result is accepted on the next edge, since res_ready is high in IDLE, giving back-to-back results with one IDLE cycle between them.
  - next_pulse on the handshake edge: discarded, because the state is still IDLE.
- Size rules: unused upper bits are latched but never displayed. page_idx never exceeds num_pages-1.
- Press latency: page advance lands between DEBOUNCE_CYCLES+2 and DEBOUNCE_CYCLES+4 cycles after the raw rising edge.

Test Plan:
- Reset, then drive res_valid with res_data=64'h1122_3344_5566_7788, size=2, sign=1 -> next cycle led=16'h7788, sign_led=1, busy=1, res_ready=0. Three debounced presses give led 5566, 3344, 1122 with page_idx 1, 2, 3. A fourth press gives one done_pulse, res_ready=1, led=0.
- Size=0, res_data=64'hFFFF_FFFF_FFFF_ABCD -> led=ABCD. A single press returns to IDLE with done_pulse; bits 63:16 are never shown.
- 32-bit result 32'hDEAD_BEEF, size=1 -> pages BEEF then DEAD. The second press ends the display; page_idx never reaches 2.
- With DEBOUNCE_CYCLES=16, apply btn_next pulses of 5 and 15 cycles -> no page change. A 20-cycle pulse -> exactly one advance, within 18-20 cycles of the raw rise.
- Assert rst low while on page 2 of a 64-bit result -> all outputs reset immediately with no done_pulse. After release with res_valid high -> a new result is accepted and led shows its page 0.
- Press the button in IDLE, then deliver a result -> display starts at page 0 (the stale press is discarded). Hold res_valid high across done_pulse -> the second result is accepted on the first IDLE edge.
